// File: rtl/approx_err_pkg.sv
// Shared types for the approximate-adder error monitor: FSM state encoding
// and the depth of the datapath behind the input handshake.
package approx_err_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Registers between an accepted sample and its commit into the statistics.
  localparam int PIPE_DEPTH = 2;

endpackage

// File: rtl/approx_err_monitor_absdiff.sv
// Combinational exact-sum and absolute-error unit for one operand pair.
// Kept free of state so formal harnesses can instantiate it directly.
module approx_abs_diff
  import approx_err_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   approx,
  output logic [WIDTH:0]   exact,
  output logic [WIDTH:0]   ae,
  output logic             mism
);

  // Exact sum, then |approx - exact| by compare-and-subtract (no signed math).
  always_comb begin
    exact = {1'b0, a} + {1'b0, b};
    if (approx >= exact) ae = approx - exact;
    else                 ae = exact - approx;
    mism = (ae != '0);
  end

endmodule

// File: rtl/approx_err_monitor.sv
// Error-statistics monitor for approximate ripple-carry adders.
// Accepts (a, b, approx) samples over a programmed window and reports error
// count, max absolute error and saturating sum of absolute errors.
// Optional macro APPROX_ERR_MON_SQ_EN adds a saturating sum of squared errors.
module approx_err_monitor
  import approx_err_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH:0]   max_ae,
  output logic [ACC_W-1:0] sum_ae
`ifdef APPROX_ERR_MON_SQ_EN
  ,
  output logic [2*(WIDTH+1)+CNT_W-1:0] sum_se
`endif
);

  localparam int AE_W = WIDTH + 1;
  // Adder width that can hold the accumulator plus one sample's error without
  // wrapping, so overflow shows up as nonzero bits above ACC_W.
  localparam int SW   = ((ACC_W > AE_W) ? ACC_W : AE_W) + 1;

  state_t              state_q, state_d;
  logic                clr, accept, done_d;
  logic [CNT_W-1:0]    win_q;
  // [0]: sample captured, [1]: stage-1 error terms valid
  logic [PIPE_DEPTH-1:0] vld_pipe;
  logic [WIDTH-1:0]    cap_a, cap_b;
  logic [AE_W-1:0]     cap_x;
  logic [AE_W-1:0]     d_exact, d_ae;
  logic                d_mism;
  logic [AE_W-1:0]     s1_ae;
  logic                s1_mism;
  logic [SW-1:0]       sum_ext;
  logic                unused_exact;

  assign accept       = in_valid & in_ready;
  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign sum_ext      = SW'(sum_ae) + SW'(s1_ae);
  assign unused_exact = ^d_exact;

  approx_abs_diff #(.WIDTH(WIDTH)) u_absdiff (
    .a      (cap_a),
    .b      (cap_b),
    .approx (cap_x),
    .exact  (d_exact),
    .ae     (d_ae),
    .mism   (d_mism)
  );

  // Next-state, accept window and done-pulse request.
  always_comb begin
    state_d  = state_q;
    clr      = 1'b0;
    done_d   = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          clr = 1'b1;
          if (win_len != '0) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        in_ready = (samples < win_q);
        if (in_valid && in_ready && ((samples + CNT_W'(1)) == win_q))
          state_d = DRAIN;
      end
      DRAIN: begin
        // Once nothing is captured, the last stage-1 entry commits this edge.
        if (!vld_pipe[0]) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
    end
  end

  // Window length latch and accepted-sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q   <= '0;
      samples <= '0;
    end else if (clr) begin
      win_q   <= win_len;
      samples <= '0;
    end else if (accept) begin
      samples <= samples + CNT_W'(1);
    end
  end

  // Sample capture register and valid shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      cap_a    <= '0;
      cap_b    <= '0;
      cap_x    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE_DEPTH-2:0], accept};
      if (accept) begin
        cap_a <= in_a;
        cap_b <= in_b;
        cap_x <= in_approx;
      end
    end
  end

  // Stage 1: register absolute error and mismatch flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_ae   <= '0;
      s1_mism <= 1'b0;
    end else if (vld_pipe[0]) begin
      s1_ae   <= d_ae;
      s1_mism <= d_mism;
    end
  end

  // Stage 2: accumulate statistics; sum_ae pins at all-ones on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      max_ae  <= '0;
      sum_ae  <= '0;
    end else if (clr) begin
      err_cnt <= '0;
      max_ae  <= '0;
      sum_ae  <= '0;
    end else if (vld_pipe[1]) begin
      err_cnt <= err_cnt + CNT_W'(s1_mism);
      if (s1_ae > max_ae) max_ae <= s1_ae;
      sum_ae  <= (|sum_ext[SW-1:ACC_W]) ? '1 : sum_ext[ACC_W-1:0];
    end
  end

`ifdef APPROX_ERR_MON_SQ_EN
  localparam int SQ_W = 2 * AE_W;
  localparam int SE_W = SQ_W + CNT_W;
  localparam int SE_X = SE_W + 1;

  logic [SQ_W-1:0] d_sq, s1_sq;
  logic [SE_W:0]   se_ext;

  assign d_sq   = SQ_W'(d_ae) * SQ_W'(d_ae);
  assign se_ext = SE_X'(sum_se) + SE_X'(s1_sq);

  // Squared error rides alongside stage 1 and accumulates in stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sq  <= '0;
      sum_se <= '0;
    end else begin
      if (vld_pipe[0]) s1_sq <= d_sq;
      if (clr)              sum_se <= '0;
      else if (vld_pipe[1]) sum_se <= se_ext[SE_W] ? '1 : se_ext[SE_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// Self-checking bench for approx_err_monitor: window results are predicted by
// a behavioural model, queued at stimulus time and compared on each done.
module tb_approx_err_monitor;

  typedef struct {
    logic [31:0] samples;
    logic [31:0] err;
    logic [16:0] max;
    logic [47:0] sum;
  } res_t;

  logic        clk, rst;
  logic        start, in_valid, in_ready, busy, done;
  logic [31:0] win_len, samples, err_cnt;
  logic [15:0] in_a, in_b;
  logic [16:0] in_approx, max_ae;
  logic [47:0] sum_ae;

  logic        start8, v8, rdy8, busy8, done8;
  logic [31:0] win8, samples8, err8;
  logic [15:0] a8, b8;
  logic [16:0] x8, max8;
  logic [7:0]  sum8;
`ifdef APPROX_ERR_MON_SQ_EN
  logic [65:0] sum_se, sum_se8;
`endif

  int   errors = 0;
  int   checks = 0;
  res_t exp_q[$];
  res_t exp8_q[$];
  res_t e_mon, e8_mon;

  approx_err_monitor u_dut (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_approx(in_approx), .busy(busy), .done(done), .samples(samples),
    .err_cnt(err_cnt), .max_ae(max_ae), .sum_ae(sum_ae)
`ifdef APPROX_ERR_MON_SQ_EN
    , .sum_se(sum_se)
`endif
  );

  approx_err_monitor #(.ACC_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .win_len(win8),
    .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_b(b8),
    .in_approx(x8), .busy(busy8), .done(done8), .samples(samples8),
    .err_cnt(err8), .max_ae(max8), .sum_ae(sum8)
`ifdef APPROX_ERR_MON_SQ_EN
    , .sum_se(sum_se8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: exact sum and absolute error in plain integer arithmetic.
  function automatic res_t acc_model(res_t r, int a, int b, int x, int accw);
    int ex, ae;
    longint s, lim;
    ex = a + b;
    ae = (x >= ex) ? x - ex : ex - x;
    r.samples = r.samples + 1;
    if (ae != 0) r.err = r.err + 1;
    if (ae > int'(r.max)) r.max = 17'(ae);
    lim = (longint'(1) << accw) - 1;
    s = longint'(r.sum) + ae;
    if (s > lim) s = lim;
    r.sum = 48'(s);
    return r;
  endfunction

  // Scoreboard compare for the main instance on every done pulse.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 with no window expected");
      end else begin
        e_mon = exp_q.pop_front();
        if (samples !== e_mon.samples) begin errors++; $display("FAIL sb_samples: got %0d expected %0d", samples, e_mon.samples); end
        checks++;
        if (err_cnt !== e_mon.err) begin errors++; $display("FAIL sb_err_cnt: got %0d expected %0d", err_cnt, e_mon.err); end
        checks++;
        if (max_ae !== e_mon.max) begin errors++; $display("FAIL sb_max_ae: got %0h expected %0h", max_ae, e_mon.max); end
        checks++;
        if (sum_ae !== e_mon.sum) begin errors++; $display("FAIL sb_sum_ae: got %0h expected %0h", sum_ae, e_mon.sum); end
      end
    end
  end

  // Scoreboard compare for the narrow-accumulator instance.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done8: done=1 with no window expected");
      end else begin
        e8_mon = exp8_q.pop_front();
        if (samples8 !== e8_mon.samples) begin errors++; $display("FAIL sb8_samples: got %0d expected %0d", samples8, e8_mon.samples); end
        checks++;
        if (err8 !== e8_mon.err) begin errors++; $display("FAIL sb8_err_cnt: got %0d expected %0d", err8, e8_mon.err); end
        checks++;
        if (max8 !== e8_mon.max) begin errors++; $display("FAIL sb8_max_ae: got %0h expected %0h", max8, e8_mon.max); end
        checks++;
        if ({40'd0, sum8} !== e8_mon.sum) begin errors++; $display("FAIL sb8_sum_ae: got %0h expected %0h", sum8, e8_mon.sum); end
      end
    end
  end

  task automatic do_start(input int w);
    start = 1'b1;
    win_len = w;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] x);
    int n;
    n = 0;
    in_a = a; in_b = b; in_approx = x; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_timeout: done=%b expected 1", name, done);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if ({in_ready, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {in_ready, busy, done}); end
    checks++; if (samples !== 32'd0 || err_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", samples, err_cnt); end
    checks++; if (max_ae !== 17'd0 || sum_ae !== 48'd0) begin errors++; $display("FAIL reset_acc: got %0h/%0h expected 0/0", max_ae, sum_ae); end
    checks++; if ({rdy8, busy8, done8} !== 3'b000) begin errors++; $display("FAIL reset_ctrl8: got %b expected 000", {rdy8, busy8, done8}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_win1();
    res_t e = '{default: '0};
    do_start(1);
    checks++; if ({busy, in_ready} !== 2'b11) begin errors++; $display("FAIL win1_run: busy,in_ready=%b expected 11", {busy, in_ready}); end
    e = acc_model(e, 100, 200, 300, 48);
    exp_q.push_back(e);
    send(16'd100, 16'd200, 17'd300);
    wait_done("win1");
    @(negedge clk);
  endtask

  task automatic test_win4();
    int ta[4] = '{'h00FF, 5, 'h1000, 3};
    int tb[4] = '{1, 5, 1, 4};
    int tx[4] = '{'h0FE, 10, 'h1006, 4};
    res_t e = '{default: '0};
    do_start(4);
    for (int i = 0; i < 4; i++) e = acc_model(e, ta[i], tb[i], tx[i], 48);
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) send(16'(ta[i]), 16'(tb[i]), 17'(tx[i]));
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL win4_drain: done,busy=%b expected 01", {done, busy}); end
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL win4_done_latency: done,busy=%b expected 10", {done, busy}); end
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL win4_done_pulse: done=%b expected 0", done); end
    checks++; if (err_cnt !== 32'd3 || max_ae !== 17'd5 || sum_ae !== 48'd10) begin
      errors++; $display("FAIL win4_hold: got %0d/%0d/%0d expected 3/5/10", err_cnt, max_ae, sum_ae);
    end
  endtask

  task automatic test_gaps();
    logic [0:9]  pat;
    logic [15:0] a, b;
    logic [16:0] x;
    int acc;
    res_t e = '{default: '0};
    pat = 10'b1001011111;
    acc = 0;
    do_start(3);
    for (int i = 0; i < 10; i++) begin
      a = 16'(i * 1000 + 7);
      b = 16'(i * 3);
      x = (17'(a) + 17'(b)) ^ 17'(i);
      in_a = a; in_b = b; in_approx = x; in_valid = pat[i];
      start = (i == 1 || i == 4);
      win_len = 7;
      if (i == 7) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL gaps_4th_ready: in_ready=%b expected 0", in_ready); end
      end
      if (in_valid && in_ready) begin
        acc++;
        e = acc_model(e, a, b, x, 48);
        if (acc == 3) exp_q.push_back(e);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0;
    checks++; if (acc != 3) begin errors++; $display("FAIL gaps_accepts: got %0d expected 3", acc); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL gaps_done_seen: pending=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_zero();
    exp_q.push_back('{default: '0});
    start = 1'b1; win_len = 0;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({done, in_ready, busy} !== 3'b100) begin errors++; $display("FAIL zero_done: done,in_ready,busy=%b expected 100", {done, in_ready, busy}); end
    @(negedge clk);
    checks++; if ({done, in_ready} !== 2'b00) begin errors++; $display("FAIL zero_after: done,in_ready=%b expected 00", {done, in_ready}); end
  endtask

  task automatic test_saturate();
    int n;
    res_t e = '{default: '0};
    for (int i = 0; i < 300; i++) e = acc_model(e, 'hFFFF, 'hFFFF, 0, 8);
    exp8_q.push_back(e);
    start8 = 1'b1; win8 = 300;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 16'hFFFF; b8 = 16'hFFFF; x8 = 17'd0; v8 = 1'b1;
    n = 0;
    while (done8 !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++; if (done8 !== 1'b1) begin errors++; $display("FAIL sat_timeout: done=%b expected 1", done8); end
    checks++; if (sum8 !== 8'hFF || rdy8 !== 1'b0) begin errors++; $display("FAIL sat_sum: sum=%0h ready=%b expected ff 0", sum8, rdy8); end
    v8 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    res_t e = '{default: '0};
    do_start(4);
    send(16'd10, 16'd20, 17'd31);
    send(16'd1, 16'd1, 17'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({in_ready, busy, done} !== 3'b000) begin errors++; $display("FAIL rstmid_ctrl: got %b expected 000", {in_ready, busy, done}); end
    checks++; if (samples !== 32'd0 || err_cnt !== 32'd0 || max_ae !== 17'd0 || sum_ae !== 48'd0) begin
      errors++; $display("FAIL rstmid_stats: got %0d/%0d/%0h/%0h expected 0", samples, err_cnt, max_ae, sum_ae);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: busy=%b expected 0", busy); end
    e = acc_model(e, 10, 20, 27, 48);
    exp_q.push_back(e);
    do_start(1);
    send(16'd10, 16'd20, 17'd27);
    wait_done("rstmid");
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0; win_len = '0; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = '0;
    start8 = 1'b0; win8 = '0; v8 = 1'b0; a8 = '0; b8 = '0; x8 = '0;
    #1 rst = 1'b1;
    test_reset();
    test_win1();
    test_win4();
    test_gaps();
    test_zero();
    test_saturate();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++; if (exp_q.size() != 0 || exp8_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: pending=%0d/%0d expected 0/0", exp_q.size(), exp8_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
